// File: rtl/seven_segment_scanner.sv
// Time-multiplexed driver for a 4-digit common-anode seven-segment display.
// Scans one hex digit per refresh slot with blanking, leading-zero suppression and decimal points.
module seven_segment_scanner #(
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned BLANK_CYC   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] value,
    input  logic [3:0]  dp_in,
    input  logic        blank_lz,
    input  logic        enable,
    output logic [7:0]  seg,
    output logic [3:0]  an,
    output logic        digit_tick
);

    localparam int unsigned CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYC);

    logic [CNT_W-1:0] cnt, cnt_d;
    logic [1:0]       idx, idx_d;
    logic [15:0]      val_q, val_d;
    logic [3:0]       dp_q, dp_d;
    logic [7:0]       seg_d;
    logic [3:0]       an_d;
    logic             tick_d;
    logic [3:0]       nib;
    logic [3:0]       suppress;

    // Active-low g..a pattern for one hex nibble, decimal point excluded
    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'h40;
            4'h1: hex7 = 7'h79;
            4'h2: hex7 = 7'h24;
            4'h3: hex7 = 7'h30;
            4'h4: hex7 = 7'h19;
            4'h5: hex7 = 7'h12;
            4'h6: hex7 = 7'h02;
            4'h7: hex7 = 7'h78;
            4'h8: hex7 = 7'h00;
            4'h9: hex7 = 7'h10;
            4'hA: hex7 = 7'h08;
            4'hB: hex7 = 7'h03;
            4'hC: hex7 = 7'h46;
            4'hD: hex7 = 7'h21;
            4'hE: hex7 = 7'h06;
            default: hex7 = 7'h0E;
        endcase
    endfunction

    // A digit is a leading zero only if it and every digit to its left are zero and its dp is off
    assign suppress = {blank_lz && (val_q[15:12] == 4'h0)  && !dp_q[3],
                       blank_lz && (val_q[15:8]  == 8'h00) && !dp_q[2],
                       blank_lz && (val_q[15:4]  == 12'h000) && !dp_q[1],
                       1'b0};

    assign nib = val_q[{idx, 2'b00} +: 4];

    always_comb begin
        cnt_d  = cnt + CNT_W'(1);
        idx_d  = idx;
        tick_d = 1'b0;
        val_d  = val_q;
        dp_d   = dp_q;
        an_d   = 4'hF;
        seg_d  = 8'hFF;

        if (cnt == CNT_MAX) begin
            cnt_d  = '0;
            idx_d  = idx + 2'd1;
            tick_d = 1'b1;
        end

        if (load) begin
            val_d = value;
            dp_d  = dp_in;
        end

        // Dark at the head of each slot so the previous digit does not ghost into the next
        if (enable && (cnt >= CNT_BLANK)) begin
            an_d = ~(4'b0001 << idx);
            if (!suppress[idx]) begin
                seg_d = {~dp_q[idx], hex7(nib)};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            idx        <= 2'd0;
            val_q      <= 16'h0000;
            dp_q       <= 4'h0;
            seg        <= 8'hFF;
            an         <= 4'hF;
            digit_tick <= 1'b0;
        end else begin
            cnt        <= cnt_d;
            idx        <= idx_d;
            val_q      <= val_d;
            dp_q       <= dp_d;
            seg        <= seg_d;
            an         <= an_d;
            digit_tick <= tick_d;
        end
    end

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Directed bench for seven_segment_scanner with REFRESH_DIV = 4, BLANK_CYC = 1.
// Outputs are sampled on the falling edge; each lit slot is one dark cycle plus three lit cycles.
module tb_seven_segment_scanner;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic        blank_lz;
    logic        enable;
    logic [7:0]  seg;
    logic [3:0]  an;
    logic        digit_tick;

    int n_vec = 0;
    int n_err = 0;

    seven_segment_scanner #(
        .REFRESH_DIV (4),
        .BLANK_CYC   (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .value      (value),
        .dp_in      (dp_in),
        .blank_lz   (blank_lz),
        .enable     (enable),
        .seg        (seg),
        .an         (an),
        .digit_tick (digit_tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] exp_an, input logic [7:0] exp_seg,
                       input logic exp_tick);
        n_vec = n_vec + 1;
        assert (an === exp_an) else begin
            n_err = n_err + 1;
            $error("FAIL %s an: got %h want %h", tag, an, exp_an);
        end
        n_vec = n_vec + 1;
        assert (seg === exp_seg) else begin
            n_err = n_err + 1;
            $error("FAIL %s seg: got %h want %h", tag, seg, exp_seg);
        end
        n_vec = n_vec + 1;
        assert (digit_tick === exp_tick) else begin
            n_err = n_err + 1;
            $error("FAIL %s digit_tick: got %b want %b", tag, digit_tick, exp_tick);
        end
    endtask

    // One slot as seen on the pins: dark cycle, then three lit cycles, tick on the last
    task automatic slot(input string tag, input logic [3:0] exp_an, input logic [7:0] exp_seg);
        @(negedge clk);
        load = 1'b0;
        chk({tag, " dark"}, 4'hF, 8'hFF, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk(tag, exp_an, exp_seg, (i == 2));
        end
    endtask

    initial begin
        rst      = 1'b1;
        load     = 1'b0;
        value    = 16'h0000;
        dp_in    = 4'h0;
        blank_lz = 1'b0;
        enable   = 1'b1;

        // Scenario 1: reset held, then first lit cycle after cnt reaches 1
        repeat (3) begin
            @(negedge clk);
            chk("rst hold", 4'hF, 8'hFF, 1'b0);
        end
        rst = 1'b0;
        @(negedge clk); chk("wake dark", 4'hF, 8'hFF, 1'b0);
        @(negedge clk); chk("wake d0 a", 4'hE, 8'hC0, 1'b0);
        @(negedge clk); chk("wake d0 b", 4'hE, 8'hC0, 1'b0);
        @(negedge clk); chk("wake d0 c", 4'hE, 8'hC0, 1'b1);

        // Scenario 2: 1234, no dp, no suppression
        value = 16'h1234; dp_in = 4'h0; load = 1'b1;
        slot("s2 d1", 4'hD, 8'hB0);
        slot("s2 d2", 4'hB, 8'hA4);
        slot("s2 d3", 4'h7, 8'hF9);
        slot("s2 d0", 4'hE, 8'h99);
        slot("s2 d1 again", 4'hD, 8'hB0);

        // Scenario 3: 00A0 with leading-zero suppression
        value = 16'h00A0; blank_lz = 1'b1; load = 1'b1;
        slot("s3 d2", 4'hB, 8'hFF);
        slot("s3 d3", 4'h7, 8'hFF);
        slot("s3 d0", 4'hE, 8'hC0);
        slot("s3 d1", 4'hD, 8'h88);

        // Scenario 4: dp on digit 2 keeps it lit
        dp_in = 4'b0100; load = 1'b1;
        slot("s4 d2", 4'hB, 8'h40);
        slot("s4 d3", 4'h7, 8'hFF);
        slot("s4 d0", 4'hE, 8'hC0);
        slot("s4 d1", 4'hD, 8'h88);

        // Scenario 5: enable low for 6 cycles mid-slot
        value = 16'h1234; dp_in = 4'h0; blank_lz = 1'b0; load = 1'b1;
        slot("s5 d2", 4'hB, 8'hA4);
        @(negedge clk); chk("s5 d3 dark", 4'hF, 8'hFF, 1'b0);
        enable = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("s5 disabled", 4'hF, 8'hFF, (i == 2));
        end
        enable = 1'b1;
        @(negedge clk); chk("s5 resume d0", 4'hE, 8'h99, 1'b1);
        slot("s5 d1", 4'hD, 8'hB0);

        // Scenario 6: load on a slot boundary, then reset mid-slot of digit 2
        value = 16'hFFFF; dp_in = 4'b0100; load = 1'b1;
        slot("s6 d2", 4'hB, 8'h0E);
        slot("s6 d3", 4'h7, 8'h8E);
        slot("s6 d0", 4'hE, 8'h8E);
        slot("s6 d1", 4'hD, 8'h8E);
        @(negedge clk); chk("s6 d2 dark", 4'hF, 8'hFF, 1'b0);
        @(negedge clk); chk("s6 d2 lit", 4'hB, 8'h0E, 1'b0);
        rst = 1'b1;
        @(negedge clk); chk("s6 rst", 4'hF, 8'hFF, 1'b0);
        rst = 1'b0;
        @(negedge clk); chk("s6 post dark", 4'hF, 8'hFF, 1'b0);
        @(negedge clk); chk("s6 post d0 a", 4'hE, 8'hC0, 1'b0);
        @(negedge clk); chk("s6 post d0 b", 4'hE, 8'hC0, 1'b0);
        @(negedge clk); chk("s6 post d0 c", 4'hE, 8'hC0, 1'b1);
        slot("s6 post d1", 4'hD, 8'hC0);
        slot("s6 post d2", 4'hB, 8'hC0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
